p2s_shift_register: RTL

//  Parallel-to-serial transmitter: accepts a WIDTH-bit word via valid/ready load

---
 rtl/p2s_defs_pkg.sv | 14 +
 rtl/p2s_bit_counter.sv | 27 ++
 rtl/p2s_shift_register.sv | 103 ++++++++++
 3 files changed

// File: rtl/p2s_defs_pkg.sv
// Shared definitions for the P2S transmit path (and the matching S2P receive side).
package p2s_defs;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  // Bits needed to hold WIDTH-1 bits remaining; never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Bits-remaining counter: loaded on frame accept, decremented on enabled steps.
module p2s_bit_counter
  import p2s_defs::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Reload on accept; count down on qualified steps, holding at zero (no wrap).
  always_ff @(posedge clk) begin
    if (rst)                      r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/p2s_shift_register.sv
// Parallel-to-serial transmitter: valid/ready word load, one bit per en step on q.
module p2s_shift_register
  import p2s_defs::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             q,
  output logic             q_valid,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  p2s_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic             r_q, r_q_valid, r_done;
  logic             w_accept, w_step, w_zero;
  logic             w_first, w_next;
  logic [WIDTH-1:0] w_sr_load, w_sr_shift;

  assign ready    = (r_state == IDLE);
  assign w_accept = load && ready;
  assign w_step   = (r_state == SHIFT) && en;

  // The first bit goes straight to q on accept, so the shift reg keeps only the
  // remaining bits; each step pops the next one from the leading end.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_first    = din[WIDTH-1];
      assign w_sr_load  = {din[WIDTH-2:0], 1'b0};
      assign w_next     = r_sr[WIDTH-1];
      assign w_sr_shift = {r_sr[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_first    = din[0];
      assign w_sr_load  = {1'b0, din[WIDTH-1:1]};
      assign w_next     = r_sr[0];
      assign w_sr_shift = {1'b0, r_sr[WIDTH-1:1]};
    end
  endgenerate

  p2s_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (CW'(WIDTH - 1)),
    .i_dec      (w_step),
    .o_zero     (w_zero)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: accept moves to SHIFT; an enabled step with no bits left ends the frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (load)          w_state_nxt = SHIFT;
      SHIFT:   if (en && w_zero)  w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr      <= '0;
      r_q       <= 1'b0;
      r_q_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sr      <= w_sr_load;
        r_q       <= w_first;
        r_q_valid <= 1'b1;
      end else if (w_step) begin
        if (!w_zero) begin
          r_q  <= w_next;
          r_sr <= w_sr_shift;
        end else begin
          r_q       <= 1'b0;
          r_q_valid <= 1'b0;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign done    = r_done;

endmodule
